// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: merges W-stage and queued multi-cycle writes onto the GRF write port,
// with WAW kill of stale queued entries and a pending-register scoreboard for the hazard unit.
module grf_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_we,
  input  logic [4:0]    p_addr,
  input  logic [31:0]   p_data,
  input  logic [31:0]   p_pc8,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [4:0]    s_addr,
  input  logic [31:0]   s_data,
  input  logic [31:0]   s_pc8,
  output logic          RegWr,
  output logic [4:0]    A3,
  output logic [31:0]   WD,
  output logic [31:0]   pc8,
  output logic [31:0]   pending,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]       q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [31:0]      q_pc8  [DEPTH];
  logic [DEPTH-1:0] vld, kill;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             p_go, pop, push, head_live;
  assign p_go      = p_we && p_addr != 5'd0;
  assign pop       = !p_go && count != '0;
  assign s_ready   = reset && count != CW'(DEPTH);
  assign push      = s_valid && s_ready && s_addr != 5'd0;
  assign head_live = !kill[rd_ptr];
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && !kill[i]) pending[q_addr[i]] = 1'b1;
    pending[0] = 1'b0;
  end
  always_ff @(posedge clk)
    if (push) begin
      q_addr[wr_ptr] <= s_addr;
      q_data[wr_ptr] <= s_data;
      q_pc8[wr_ptr]  <= s_pc8;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
      kill   <= '0;
      count  <= '0;
      RegWr  <= 1'b0;
      A3     <= '0;
      WD     <= '0;
      pc8    <= '0;
    end else begin
      // an issuing primary write supersedes any older queued write to the same register
      if (p_go)
        for (int i = 0; i < DEPTH; i++)
          if (vld[i] && q_addr[i] == p_addr) kill[i] <= 1'b1;
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (push) begin
        vld[wr_ptr]  <= 1'b1;
        kill[wr_ptr] <= 1'b0;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      RegWr <= p_go || (pop && head_live);
      if (p_go) begin
        A3  <= p_addr;
        WD  <= p_data;
        pc8 <= p_pc8;
      end else if (pop && head_live) begin
        A3  <= q_addr[rd_ptr];
        WD  <= q_data[rd_ptr];
        pc8 <= q_pc8[rd_ptr];
      end
    end
endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb_grf_write_arbiter: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_grf_write_arbiter;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  logic          clk = 0, reset = 0;
  logic          p_we = 0, s_valid = 0;
  logic [4:0]    p_addr = 0, s_addr = 0;
  logic [31:0]   p_data = 0, p_pc8 = 0, s_data = 0, s_pc8 = 0;
  logic          s_ready, RegWr;
  logic [4:0]    A3;
  logic [31:0]   WD, pc8, pending;
  logic [CW-1:0] count;
  int n_chk = 0, n_fail = 0;

  grf_write_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc8(p_pc8),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data), .s_pc8(s_pc8),
    .RegWr(RegWr), .A3(A3), .WD(WD), .pc8(pc8), .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc8;
    bit          killed;
  } ent_t;
  ent_t        q[$];
  ent_t        h;
  logic        m_we = 0;
  logic [4:0]  m_a3 = 0;
  logic [31:0] m_wd = 0, m_pc8 = 0;
  bit          m_acc;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p = 0;
    foreach (q[i]) if (!q[i].killed) p[q[i].addr] = 1'b1;
    return p;
  endfunction

  // Reference: FIFO as a queue; primary wins the slot, kills older same-register entries
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_we = 0; m_a3 = 0; m_wd = 0; m_pc8 = 0;
    end else begin
      m_acc = s_valid && q.size() < DEPTH;
      if (p_we && p_addr != 0) begin
        m_we = 1; m_a3 = p_addr; m_wd = p_data; m_pc8 = p_pc8;
        foreach (q[i]) if (q[i].addr == p_addr) q[i].killed = 1;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        m_we = !h.killed;
        if (!h.killed) begin m_a3 = h.addr; m_wd = h.data; m_pc8 = h.pc8; end
      end else m_we = 0;
      if (m_acc && s_addr != 0) q.push_back('{s_addr, s_data, s_pc8, 1'b0});
    end
  end

  always @(posedge clk) begin
    #1;
    chk("RegWr", RegWr, m_we);
    chk("A3", A3, m_a3);
    chk("WD", WD, m_wd);
    chk("pc8", pc8, m_pc8);
    chk("count", count, q.size());
    chk("pending", pending, m_pending());
    chk("s_ready", s_ready, reset && q.size() < DEPTH);
    chk("a3_zero_write", RegWr && A3 == 0, 0);
  end

  task automatic set(bit pwe, logic [4:0] pa, logic [31:0] pd, logic [31:0] pp,
                     bit sv, logic [4:0] sa, logic [31:0] sd, logic [31:0] sp);
    p_we = pwe; p_addr = pa; p_data = pd; p_pc8 = pp;
    s_valid = sv; s_addr = sa; s_data = sd; s_pc8 = sp;
  endtask

  task automatic edge_();
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    chk("rst_RegWr", RegWr, 0);
    chk("rst_count", count, 0);
    chk("rst_s_ready", s_ready, 0);
    @(negedge clk) reset = 1;
    #1 chk("rel_s_ready", s_ready, 1);

    // secondary only
    @(negedge clk) set(0, 0, 0, 0, 1, 5, 32'h1234, 32'h3008);
    edge_();
    chk("sec_pend1", pending[5], 1);
    chk("sec_wait", RegWr, 0);
    @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0);
    edge_();
    chk("sec_we", RegWr, 1);
    chk("sec_a3", A3, 5);
    chk("sec_wd", WD, 32'h1234);
    chk("sec_pc8", pc8, 32'h3008);
    chk("sec_pend0", pending[5], 0);

    // priority and backpressure
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) set(1, 1, 32'h100 + i, 32'h40, 1, 5'(10 + i), 32'h200 + i, 32'h50 + i);
      edge_();
      chk("bp_prim", A3, 1);
    end
    @(negedge clk) set(1, 1, 32'h1FF, 32'h40, 1, 20, 32'h2FF, 32'h5F);
    #1;
    chk("bp_count", count, 4);
    chk("bp_ready", s_ready, 0);
    edge_();
    chk("bp_prim_wd", WD, 32'h1FF);
    @(negedge clk) set(0, 0, 0, 0, 1, 20, 32'h2FF, 32'h5F);
    for (int i = 0; i < 4; i++) begin
      edge_();
      chk("drain_we", RegWr, 1);
      chk("drain_a3", A3, 10 + i);
      chk("drain_wd", WD, 32'h200 + i);
      @(negedge clk) if (i == 1) s_valid = 0;
    end
    edge_();
    chk("drain5_wd", WD, 32'h2FF);

    // WAW kill
    @(negedge clk) set(0, 0, 0, 0, 1, 7, 32'hAAAA, 32'h70);
    edge_();
    chk("waw_pend", pending[7], 1);
    @(negedge clk) set(1, 7, 32'hBBBB, 32'h74, 0, 0, 0, 0);
    edge_();
    chk("waw_wd", WD, 32'hBBBB);
    chk("waw_pend0", pending[7], 0);
    chk("waw_cnt", count, 1);
    @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0);
    edge_();
    chk("waw_kill_we", RegWr, 0);
    chk("waw_hold_wd", WD, 32'hBBBB);

    // zero register
    @(negedge clk) set(0, 0, 0, 0, 1, 3, 32'h55, 32'h30);
    edge_();
    @(negedge clk) set(1, 0, 32'hDEAD, 32'h99, 0, 0, 0, 0);
    edge_();
    chk("z_we", RegWr, 1);
    chk("z_a3", A3, 3);
    chk("z_wd", WD, 32'h55);
    @(negedge clk) set(0, 0, 0, 0, 1, 0, 32'h77, 32'h33);
    #1 chk("z_ready", s_ready, 1);
    edge_();
    chk("z_cnt", count, 0);
    @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0);
    edge_();
    chk("z_idle", RegWr, 0);

    // reset mid-queue
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) set(1, 2, 32'h22, 32'h20, 1, 5'(12 + i), 32'h300 + i, 0);
      edge_();
    end
    chk("mq_cnt", count, 3);
    @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 0;
    #1;
    chk("mq_we", RegWr, 0);
    chk("mq_cnt0", count, 0);
    chk("mq_pend", pending, 0);
    chk("mq_ready0", s_ready, 0);
    @(negedge clk) reset = 1;
    #1 chk("mq_ready1", s_ready, 1);

    // wrap with simultaneous push and pop
    for (int i = 0; i < 3 * DEPTH; i++) begin
      @(negedge clk) set(0, 0, 0, 0, 1, 9, 32'h1000 + i, 32'h9000 + i);
      edge_();
      chk("wr_cnt", count, 1);
      if (i > 0) chk("wr_wd", WD, 32'h1000 + i - 1);
    end
    @(negedge clk) set(0, 0, 0, 0, 0, 0, 0, 0);
    edge_();
    chk("wr_last", WD, 32'h1000 + 3 * DEPTH - 1);
    chk("wr_cnt0", count, 0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
